// File: rtl/pu_ctrl_pkg.sv
// Shared definitions for the PU sequencing controller.
// Holds the FSM state encoding and the default sizing constants used by
// pu_controller and its counters.
package pu_ctrl_pkg;

    // Default sizing for the 4-lane processing unit.
    localparam int unsigned DefNumNeurons = 4;
    localparam int unsigned DefAddCycles  = 1;
    localparam int unsigned DefMaxIter    = 16;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StInit   = 3'd1,
        StMult   = 3'd2,
        StAdd    = 3'd3,
        StStore  = 3'd4,
        StUpdate = 3'd5,
        StCheck  = 3'd6,
        StDone   = 3'd7
    } state_e;

endpackage

// File: rtl/pu_ctrl_counter.sv
// Saturating up-counter with synchronous clear, enable and terminal count.
// Ports:
//   clk, rst  - clock and asynchronous active-high reset
//   clr       - synchronous clear to zero (priority over en)
//   en        - count up by one; holds once the terminal value is reached
//   count     - current value
//   tc        - high while count equals Max
module pu_ctrl_counter #(
    parameter int unsigned Width = 2,
    parameter int unsigned Max   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [Width-1:0] count,
    output logic             tc
);

    logic [Width-1:0] count_q, count_d;

    assign tc    = (count_q == Width'(Max));
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && !tc) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pu_controller.sv
// Sequencing FSM for the 4-lane floating-point processing unit.
// Evaluates every neuron once per iteration (multiply, settle adder tree,
// store), copies the activation bank back into the PU inputs, then checks
// the one-left detector or the iteration limit to decide whether to stop.
// Ports:
//   clk, rst    - clock and asynchronous active-high reset
//   start       - begin a run (only honoured in idle)
//   one_left    - exactly one nonzero activation remains in the input bank
//   busy        - high in every state except idle
//   done        - one-cycle pulse ending a run
//   timeout     - last run stopped on the iteration limit; held until next start
//   x_init      - load external inputs into the PU input bank
//   x_update    - copy activation bank into the PU input bank
//   sel         - neuron whose weight row feeds the multipliers
//   mult_write  - mult register bank write enable
//   out_write   - write adder-tree result to activation slot out_idx
//   out_idx     - activation slot index (same as sel)
//   iter        - completed iterations in the current run
module pu_controller
    import pu_ctrl_pkg::*;
#(
    parameter int unsigned NUM_NEURONS = DefNumNeurons,
    parameter int unsigned ADD_CYCLES  = DefAddCycles,
    parameter int unsigned MAX_ITER    = DefMaxIter,
    parameter int unsigned IDX_W       = $clog2(NUM_NEURONS),
    parameter int unsigned ITER_W      = $clog2(MAX_ITER + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              one_left,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              x_init,
    output logic              x_update,
    output logic [IDX_W-1:0]  sel,
    output logic              mult_write,
    output logic              out_write,
    output logic [IDX_W-1:0]  out_idx,
    output logic [ITER_W-1:0] iter
);

    // Settle counter spans 0..ADD_CYCLES-1; keep at least one bit.
    localparam int unsigned SetW = (ADD_CYCLES > 1) ? $clog2(ADD_CYCLES) : 1;

    state_e state_q, state_d;
    logic   timeout_q, timeout_d;

    logic sel_clr, sel_en, sel_tc;
    logic iter_clr, iter_en, iter_tc;
    logic set_clr, set_en, set_tc;

    logic [SetW-1:0] set_count;
    logic            unused_set_count;

    assign unused_set_count = ^set_count;

    pu_ctrl_counter #(
        .Width (IDX_W),
        .Max   (NUM_NEURONS - 1)
    ) u_sel_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (sel_clr),
        .en    (sel_en),
        .count (sel),
        .tc    (sel_tc)
    );

    pu_ctrl_counter #(
        .Width (ITER_W),
        .Max   (MAX_ITER)
    ) u_iter_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (iter_clr),
        .en    (iter_en),
        .count (iter),
        .tc    (iter_tc)
    );

    pu_ctrl_counter #(
        .Width (SetW),
        .Max   (ADD_CYCLES - 1)
    ) u_settle_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (set_clr),
        .en    (set_en),
        .count (set_count),
        .tc    (set_tc)
    );

    // Settle counter only runs in ADD and sits at zero everywhere else.
    assign set_en  = (state_q == StAdd);
    assign set_clr = (state_q != StAdd);

    always_comb begin
        state_d    = state_q;
        timeout_d  = timeout_q;
        sel_clr    = 1'b0;
        sel_en     = 1'b0;
        iter_clr   = 1'b0;
        iter_en    = 1'b0;
        x_init     = 1'b0;
        x_update   = 1'b0;
        mult_write = 1'b0;
        out_write  = 1'b0;
        done       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) state_d = StInit;
            end
            StInit: begin
                x_init    = 1'b1;
                sel_clr   = 1'b1;
                iter_clr  = 1'b1;
                timeout_d = 1'b0;
                state_d   = StMult;
            end
            StMult: begin
                mult_write = 1'b1;
                state_d    = StAdd;
            end
            StAdd: begin
                if (set_tc) state_d = StStore;
            end
            StStore: begin
                out_write = 1'b1;
                if (sel_tc) begin
                    state_d = StUpdate;
                end else begin
                    sel_en  = 1'b1;
                    state_d = StMult;
                end
            end
            StUpdate: begin
                x_update = 1'b1;
                iter_en  = 1'b1;
                state_d  = StCheck;
            end
            StCheck: begin
                // one_left takes priority over the iteration limit.
                if (one_left) begin
                    timeout_d = 1'b0;
                    state_d   = StDone;
                end else if (iter_tc) begin
                    timeout_d = 1'b1;
                    state_d   = StDone;
                end else begin
                    sel_clr = 1'b1;
                    state_d = StMult;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timeout_q <= timeout_d;
        end
    end

    assign busy    = (state_q != StIdle);
    assign timeout = timeout_q;
    assign out_idx = sel;

endmodule

// File: tb/tb_pu_controller.sv
// Directed self-checking bench for pu_controller.
// dut  : default sizing (4 neurons, 1 add cycle, 16 iterations)
// dut2 : 2 neurons, 3 add cycles
module tb_pu_controller;

    logic clk = 1'b0;
    logic rst;

    logic       start, one_left;
    logic       busy, done, timeout, x_init, x_update, mult_write, out_write;
    logic [1:0] sel, out_idx;
    logic [4:0] iter;

    logic       start2, one_left2;
    logic       busy2, done2, timeout2, x_init2, x_update2, mult_write2, out_write2;
    logic [0:0] sel2, out_idx2;
    logic [4:0] iter2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pu_controller dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .one_left   (one_left),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .x_init     (x_init),
        .x_update   (x_update),
        .sel        (sel),
        .mult_write (mult_write),
        .out_write  (out_write),
        .out_idx    (out_idx),
        .iter       (iter)
    );

    pu_controller #(
        .NUM_NEURONS (2),
        .ADD_CYCLES  (3)
    ) dut2 (
        .clk        (clk),
        .rst        (rst),
        .start      (start2),
        .one_left   (one_left2),
        .busy       (busy2),
        .done       (done2),
        .timeout    (timeout2),
        .x_init     (x_init2),
        .x_update   (x_update2),
        .sel        (sel2),
        .mult_write (mult_write2),
        .out_write  (out_write2),
        .out_idx    (out_idx2),
        .iter       (iter2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [6:0] got;
        rst = 1'b1; start = 1'b0; one_left = 1'b0; start2 = 1'b0; one_left2 = 1'b0;
        tick();
        tick();
        got = {busy, done, timeout, x_init, x_update, mult_write, out_write};
        n_checks++;
        if (got !== 7'b0) $display("FAIL reset_outputs: got %b want 0000000", got);
        else n_pass++;
        n_checks++;
        if (sel !== 2'd0 || iter !== 5'd0)
            $display("FAIL reset_counters: sel=%0d iter=%0d want 0/0", sel, iter);
        else n_pass++;
        rst = 1'b0;
        tick();
    endtask

    // Strobe vector order: {x_init, mult_write, out_write, x_update, done, busy}
    task automatic test_single_iter();
        logic [5:0] exp, got;
        one_left = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            exp = 6'b0;
            exp[0] = (c <= 16);
            if (c == 1) exp[5] = 1'b1;
            if (c == 2 || c == 5 || c == 8 || c == 11) exp[4] = 1'b1;
            if (c == 4 || c == 7 || c == 10 || c == 13) exp[3] = 1'b1;
            if (c == 14) exp[2] = 1'b1;
            if (c == 16) exp[1] = 1'b1;
            got = {x_init, mult_write, out_write, x_update, done, busy};
            n_checks++;
            if (got !== exp) $display("FAIL single_strobes c=%0d: got %b want %b", c, got, exp);
            else n_pass++;
            if (exp[3]) begin
                n_checks++;
                if (out_idx !== 2'((c - 4) / 3))
                    $display("FAIL single_out_idx c=%0d: got %0d want %0d", c, out_idx, (c - 4) / 3);
                else n_pass++;
            end
            if (c == 16) begin
                n_checks++;
                if (timeout !== 1'b0 || iter !== 5'd1)
                    $display("FAIL single_end: timeout=%b iter=%0d want 0/1", timeout, iter);
                else n_pass++;
            end
            tick();
        end
    endtask

    // Strobe vector order: {x_init, mult_write, out_write, x_update, done, busy}
    task automatic test_param();
        logic [5:0] exp, got;
        one_left2 = 1'b1;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            exp = 6'b0;
            exp[0] = (c <= 14);
            if (c == 1) exp[5] = 1'b1;
            if (c == 2 || c == 7) exp[4] = 1'b1;
            if (c == 6 || c == 11) exp[3] = 1'b1;
            if (c == 12) exp[2] = 1'b1;
            if (c == 14) exp[1] = 1'b1;
            got = {x_init2, mult_write2, out_write2, x_update2, done2, busy2};
            n_checks++;
            if (got !== exp) $display("FAIL param_strobes c=%0d: got %b want %b", c, got, exp);
            else n_pass++;
            if (exp[3]) begin
                n_checks++;
                if (out_idx2 !== 1'((c == 11) ? 1 : 0))
                    $display("FAIL param_out_idx c=%0d: got %0d", c, out_idx2);
                else n_pass++;
            end
            if (c == 14) begin
                n_checks++;
                if (iter2 !== 5'd1 || timeout2 !== 1'b0)
                    $display("FAIL param_end: iter=%0d timeout=%b want 1/0", iter2, timeout2);
                else n_pass++;
            end
            tick();
        end
    endtask

    // one_left rises in the CHECK cycle where iter has just reached the limit.
    task automatic test_tie();
        int xu = 0;
        int done_c = 0;
        one_left = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            if (done) begin
                done_c = c;
                break;
            end
            if (x_update) begin
                xu++;
                if (xu == 16) one_left = 1'b1;
            end
            tick();
        end
        n_checks++;
        if (done_c !== 226) $display("FAIL tie_done_cycle: got %0d want 226", done_c);
        else n_pass++;
        n_checks++;
        if (timeout !== 1'b0 || iter !== 5'd16)
            $display("FAIL tie_end: timeout=%b iter=%0d want 0/16", timeout, iter);
        else n_pass++;
        tick();
    endtask

    task automatic test_timeout();
        int xu = 0;
        int done_c = 0;
        one_left = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            if (done) begin
                done_c = c;
                break;
            end
            if (x_update) xu++;
            tick();
        end
        n_checks++;
        if (done_c !== 226) $display("FAIL timeout_done_cycle: got %0d want 226", done_c);
        else n_pass++;
        n_checks++;
        if (xu !== 16) $display("FAIL timeout_updates: got %0d want 16", xu);
        else n_pass++;
        n_checks++;
        if (timeout !== 1'b1 || iter !== 5'd16)
            $display("FAIL timeout_end: timeout=%b iter=%0d want 1/16", timeout, iter);
        else n_pass++;
        repeat (3) tick();
        n_checks++;
        if (timeout !== 1'b1 || busy !== 1'b0)
            $display("FAIL timeout_hold: timeout=%b busy=%b want 1/0", timeout, busy);
        else n_pass++;
        // Next run clears the flag in INIT and completes normally.
        one_left = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        n_checks++;
        if (timeout !== 1'b0 || mult_write !== 1'b1)
            $display("FAIL timeout_clear: timeout=%b mult_write=%b want 0/1", timeout, mult_write);
        else n_pass++;
        done_c = 0;
        for (int c = 2; c <= 40; c++) begin
            if (done) begin
                done_c = c;
                break;
            end
            tick();
        end
        n_checks++;
        if (done_c !== 16 || timeout !== 1'b0)
            $display("FAIL timeout_rerun: done_cycle=%0d timeout=%b want 16/0", done_c, timeout);
        else n_pass++;
        tick();
    endtask

    // start pulsed in STORE (cycle 4) and in DONE (cycle 16) must be ignored.
    task automatic test_start_busy();
        logic [5:0] exp, got;
        one_left = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 19; c++) begin
            exp = 6'b0;
            exp[0] = (c <= 16);
            if (c == 1) exp[5] = 1'b1;
            if (c == 2 || c == 5 || c == 8 || c == 11) exp[4] = 1'b1;
            if (c == 4 || c == 7 || c == 10 || c == 13) exp[3] = 1'b1;
            if (c == 14) exp[2] = 1'b1;
            if (c == 16) exp[1] = 1'b1;
            got = {x_init, mult_write, out_write, x_update, done, busy};
            n_checks++;
            if (got !== exp) $display("FAIL busy_start c=%0d: got %b want %b", c, got, exp);
            else n_pass++;
            start = (c == 4 || c == 16);
            tick();
        end
        start = 1'b0;
    endtask

    // Reset during ADD of neuron 2 in the second iteration (cycle 23).
    task automatic test_reset_mid_run();
        logic [6:0] got;
        int activity = 0;
        one_left = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (22) tick();
        n_checks++;
        if (sel !== 2'd2 || iter !== 5'd1 || busy !== 1'b1)
            $display("FAIL midrst_pre: sel=%0d iter=%0d busy=%b want 2/1/1", sel, iter, busy);
        else n_pass++;
        rst = 1'b1;
        #1;
        got = {busy, done, timeout, x_init, x_update, mult_write, out_write};
        n_checks++;
        if (got !== 7'b0 || sel !== 2'd0 || iter !== 5'd0)
            $display("FAIL midrst_clear: outs=%b sel=%0d iter=%0d want 0/0/0", got, sel, iter);
        else n_pass++;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (busy || done || x_init || x_update || mult_write || out_write) activity++;
            tick();
        end
        n_checks++;
        if (activity !== 0) $display("FAIL midrst_quiet: active cycles %0d want 0", activity);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_iter();
        test_param();
        test_tie();
        test_timeout();
        test_start_busy();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pu_controller.md
Name: pu_controller

Overview:
- Sequencing FSM for the 4-lane floating-point processing unit (multiplier bank → mult register bank → 2-level adder tree).
- Runs one PU evaluation per neuron, writes each result to the activation bank, then updates the PU inputs from that bank for the next iteration.
- Stops when the external "one-left" detector fires or the iteration limit is hit, then reports done/timeout to the top-level.

Parameters:
- NUM_NEURONS, 4, neurons evaluated per iteration; must be ≥2.
- ADD_CYCLES, 1, cycles allowed for the combinational adder tree to settle after mult_write; must be ≥1.
- MAX_ITER, 16, iteration limit before forced termination; must be ≥1.
- IDX_W, $clog2(NUM_NEURONS), width of neuron index.
- ITER_W, $clog2(MAX_ITER+1), width of iteration count.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a run; sampled only in IDLE.
- one_left  input  1  from the comparator on the current input bank; 1 when exactly one nonzero activation remains.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at the end of a run.
- timeout  output  1  run ended on MAX_ITER without one_left; held until the next accepted start.
- x_init  output  1  load external inputs into the PU input bank.
- x_update  output  1  copy the activation bank into the PU input bank.
- sel  output  IDX_W  neuron whose weight row drives w1..w4.
- mult_write  output  1  write enable of the mult register bank.
- out_write  output  1  write adder-tree result into activation slot out_idx.
- out_idx  output  IDX_W  activation slot index; equals sel.
- iter  output  ITER_W  completed iterations in the current run.

Behaviour:
- All registers are cleared asynchronously on rst.
  - State returns to IDLE.
  - sel, iter, timeout and the settle counter go to 0.
  - All strobes and done go to 0.
- Reset mid-run aborts the run immediately. No done pulse is generated.
- x_init, x_update, mult_write, out_write and done are Moore outputs decoded from state. Each is high for exactly its state's cycle(s).
- States and transitions:
  - IDLE: start=1 → INIT. start in any other state is ignored (no queuing).
  - INIT (1 cycle): x_init=1. Clear sel, iter and timeout. → MULT.
  - MULT (1 cycle): mult_write=1. → ADD.
  - ADD (ADD_CYCLES cycles): settle counter counts 0..ADD_CYCLES-1. → STORE on terminal count.
  - STORE (1 cycle): out_write=1, out_idx=sel.
    - If sel==NUM_NEURONS-1 → UPDATE.
    - Else sel+1 → MULT.
  - UPDATE (1 cycle): x_update=1, iter+1. → CHECK.
  - CHECK (1 cycle): one_left is sampled here, after the bank update has propagated.
    - one_left=1 → DONE with timeout=0.
    - Else if iter==MAX_ITER → DONE with timeout=1.
    - Else sel=0 → MULT.
  - DONE (1 cycle): done=1. → IDLE.
- Simultaneous one_left=1 and iter==MAX_ITER in CHECK: one_left wins, timeout=0.
- sel holds its value in MULT, ADD and STORE. It wraps only through the explicit clear in CHECK/INIT, never by overflow.
- Iteration length is NUM_NEURONS*(2+ADD_CYCLES)+2 cycles.
- Run length from the start-sample edge to the done cycle is 1 + iterations*(iteration length) + 1.
  - Example: defaults, one iteration = 16 cycles.
- busy=1 from INIT through DONE inclusive.

Decomposition:
- Shared package pu_ctrl_pkg holds:
  - State encodings: IDLE, INIT, MULT, ADD, STORE, UPDATE, CHECK, DONE (3-bit).
  - Default NUM_NEURONS, ADD_CYCLES and MAX_ITER constants.
- One sub-module, pu_ctrl_counter: a parameterised up-counter with sync clear, enable and terminal-count output. It is instanced three times, for sel, iter and the settle counter.

Test Plan:
- Reset during ADD of neuron 2 (rst=1 for 1 cycle) → next cycle IDLE, busy=0, sel=0, iter=0, no done pulse, no further strobes.
- Defaults, start at cycle 0, one_left=1 → x_init at cycle 1, mult_write at cycles 2/5/8/11, out_write at 4/7/10/13 with out_idx 0/1/2/3, x_update at 14, done at 16, timeout=0, iter=1.
- Defaults, one_left held 0 → exactly 16 x_update pulses, then done with timeout=1 and iter=16. timeout stays 1 until the next start, then clears in INIT.
- one_left rises together with iter reaching MAX_ITER in CHECK → timeout=0.
- ADD_CYCLES=3, NUM_NEURONS=2, one_left=1 → each mult_write followed by out_write 4 cycles later, done 14 cycles after start.
- start pulsed while busy (in STORE and in DONE) → run unaffected, IDLE reached after DONE, no second run started.
